snake_engine: RTL and testbench

Game-logic stage driving port B of the snake board RAM (32×16 cells, 4-bit cell codes); the display reads the same RAM on its other port. On each game tick it moves the snake one cell, detects collisions and food, grows or advances the tail, and keeps board contents consistent. After reset it clears the board and draws the initial snake.

---
 rtl/snake_pkg.sv | 43 ++++
 rtl/snake_next_pos.sv | 30 +++
 rtl/snake_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_snake_engine.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game engine: board size, cell codes,
// direction codes and FSM state encoding.
package snake_pkg;

    localparam int BOARD_WIDTH  = 32;
    localparam int BOARD_HEIGHT = 16;

    localparam logic [3:0] CELL_EMPTY = 4'd0;
    localparam logic [3:0] CELL_FOOD  = 4'd1;
    localparam logic [3:0] CELL_WALL  = 4'd2;
    localparam logic [3:0] CELL_RSVD  = 4'd3;
    localparam logic [3:0] CELL_BODY  = 4'd4;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef logic [3:0] state_t;

    localparam state_t ST_CLEAR    = 4'd0;
    localparam state_t ST_INIT     = 4'd1;
    localparam state_t ST_IDLE     = 4'd2;
    localparam state_t ST_RD_HEAD  = 4'd3;
    localparam state_t ST_CHECK    = 4'd4;
    localparam state_t ST_WR_OLD   = 4'd5;
    localparam state_t ST_WR_NEW   = 4'd6;
    localparam state_t ST_RD_TAIL  = 4'd7;
    localparam state_t ST_TAIL_CHK = 4'd8;
    localparam state_t ST_WR_TAIL  = 4'd9;
    localparam state_t ST_OVER     = 4'd10;

    // Body code records the direction toward the next segment nearer the head.
    function automatic logic [3:0] body_code(input logic [1:0] d);
        return {2'b01, d};
    endfunction

    // Wall, reserved and any body segment all end the game.
    function automatic logic is_blocked(input logic [3:0] code);
        return code >= CELL_WALL;
    endfunction

endpackage

// File: rtl/snake_next_pos.sv
// Combinational neighbour of a board cell in a given direction; coordinates
// wrap because the board dimensions are powers of two.
module snake_next_pos
    import snake_pkg::*;
#(
    parameter int WIDTH  = BOARD_WIDTH,
    parameter int HEIGHT = BOARD_HEIGHT,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    dir,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny
);

    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_UP:    ny = y - YW'(1);
            DIR_RIGHT: nx = x + XW'(1);
            DIR_DOWN:  ny = y + YW'(1);
            DIR_LEFT:  nx = x - XW'(1);
            default:   ;
        endcase
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game logic on RAM port B: clears and seeds the board, then moves,
// grows and collision-checks the snake once per accepted tick.
//
// state    | meaning
// CLEAR    | write EMPTY to every cell, row-major from (0,0)
// INIT     | draw the initial horizontal snake, head rightmost
// IDLE     | wait for tick, latch direction (reversals ignored)
// RD_HEAD  | read the cell the head moves into
// CHECK    | classify that cell: collision, food or empty
// WR_OLD   | rewrite old head as body pointing at new head
// WR_NEW   | write new head, grow on food
// RD_TAIL  | read tail cell to learn where the body continues
// TAIL_CHK | latch tail direction from read data
// WR_TAIL  | clear tail cell and step tail forward
// OVER     | collision seen; frozen until reset
module snake_engine
    import snake_pkg::*;
#(
    parameter int WIDTH    = BOARD_WIDTH,
    parameter int HEIGHT   = BOARD_HEIGHT,
    parameter int INIT_LEN = 3,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [1:0]    dir_in,
    output logic [XW-1:0] x_b,
    output logic [YW-1:0] y_b,
    output logic          read_b,
    output logic          write_b,
    output logic [3:0]    in_b,
    input  logic [3:0]    out_b,
    output logic          busy,
    output logic          game_over,
    output logic          ate,
    output logic [8:0]    length
);

    localparam int CW = XW + YW;
    localparam logic [CW-1:0] CLEAR_LAST = CW'(WIDTH * HEIGHT - 1);
    localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_LEN - 1);
    localparam logic [XW-1:0] INIT_X0    = XW'(WIDTH / 2 - INIT_LEN + 1);
    localparam logic [XW-1:0] HEAD_X0    = XW'(WIDTH / 2);
    localparam logic [YW-1:0] START_ROW  = YW'(HEIGHT / 2);
    localparam logic [8:0]    LEN_MAX    = 9'h1FF;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    dir;
    logic [1:0]    dir_req;
    logic [1:0]    tail_d;
    logic          grow;
    logic [XW-1:0] head_x, tail_x, new_x, tail_nx;
    logic [YW-1:0] head_y, tail_y, new_y, tail_ny;

    snake_next_pos #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_head_pos (
        .x   (head_x),
        .y   (head_y),
        .dir (dir),
        .nx  (new_x),
        .ny  (new_y)
    );

    snake_next_pos #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_tail_pos (
        .x   (tail_x),
        .y   (tail_y),
        .dir (tail_d),
        .nx  (tail_nx),
        .ny  (tail_ny)
    );

    assign dir_req = (dir_in == (dir ^ 2'd2)) ? dir : dir_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            dir       <= DIR_UP;
            tail_d    <= DIR_UP;
            grow      <= 1'b0;
            head_x    <= '0;
            head_y    <= '0;
            tail_x    <= '0;
            tail_y    <= '0;
            length    <= '0;
            game_over <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == CLEAR_LAST) begin
                        cnt   <= '0;
                        state <= ST_INIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_INIT: begin
                    if (cnt == INIT_LAST) begin
                        cnt    <= '0;
                        dir    <= DIR_RIGHT;
                        head_x <= HEAD_X0;
                        head_y <= START_ROW;
                        tail_x <= INIT_X0;
                        tail_y <= START_ROW;
                        length <= 9'(INIT_LEN);
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (tick) begin
                        dir   <= dir_req;
                        state <= ST_RD_HEAD;
                    end
                end
                ST_RD_HEAD: state <= ST_CHECK;
                ST_CHECK: begin
                    if (is_blocked(out_b)) begin
                        game_over <= 1'b1;
                        state     <= ST_OVER;
                    end else begin
                        grow  <= (out_b == CELL_FOOD);
                        state <= ST_WR_OLD;
                    end
                end
                ST_WR_OLD: state <= ST_WR_NEW;
                ST_WR_NEW: begin
                    head_x <= new_x;
                    head_y <= new_y;
                    if (grow) begin
                        if (length != LEN_MAX) length <= length + 9'd1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RD_TAIL;
                    end
                end
                ST_RD_TAIL:  state <= ST_TAIL_CHK;
                ST_TAIL_CHK: begin
                    tail_d <= out_b[1:0];
                    state  <= ST_WR_TAIL;
                end
                ST_WR_TAIL: begin
                    tail_x <= tail_nx;
                    tail_y <= tail_ny;
                    state  <= ST_IDLE;
                end
                ST_OVER: state <= ST_OVER;
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // RAM controls follow the current state; rst masks them so an interrupted
    // step never lands a stray write.
    always_comb begin
        x_b     = '0;
        y_b     = '0;
        read_b  = 1'b0;
        write_b = 1'b0;
        in_b    = CELL_EMPTY;
        if (!rst) begin
            case (state)
                ST_CLEAR: begin
                    x_b     = cnt[XW-1:0];
                    y_b     = cnt[CW-1:XW];
                    write_b = 1'b1;
                end
                ST_INIT: begin
                    x_b     = INIT_X0 + cnt[XW-1:0];
                    y_b     = START_ROW;
                    write_b = 1'b1;
                    in_b    = body_code(DIR_RIGHT);
                end
                ST_RD_HEAD: begin
                    x_b    = new_x;
                    y_b    = new_y;
                    read_b = 1'b1;
                end
                ST_CHECK: begin
                    x_b = new_x;
                    y_b = new_y;
                end
                ST_WR_OLD: begin
                    x_b     = head_x;
                    y_b     = head_y;
                    write_b = 1'b1;
                    in_b    = body_code(dir);
                end
                ST_WR_NEW: begin
                    x_b     = new_x;
                    y_b     = new_y;
                    write_b = 1'b1;
                    in_b    = body_code(dir);
                end
                ST_RD_TAIL: begin
                    x_b    = tail_x;
                    y_b    = tail_y;
                    read_b = 1'b1;
                end
                ST_TAIL_CHK: begin
                    x_b = tail_x;
                    y_b = tail_y;
                end
                ST_WR_TAIL: begin
                    x_b     = tail_x;
                    y_b     = tail_y;
                    write_b = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = rst | ((state != ST_IDLE) && (state != ST_OVER));
    assign ate  = !rst && (state == ST_WR_NEW) && grow;

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine with a behavioural port-B RAM.
module tb_snake_engine;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic [4:0] x_b;
    logic [3:0] y_b;
    logic       read_b, write_b;
    logic [3:0] in_b;
    logic [3:0] out_b;
    logic       busy, game_over, ate;
    logic [8:0] length;

    always #5 clk = ~clk;

    snake_engine dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .dir_in    (dir_in),
        .x_b       (x_b),
        .y_b       (y_b),
        .read_b    (read_b),
        .write_b   (write_b),
        .in_b      (in_b),
        .out_b     (out_b),
        .busy      (busy),
        .game_over (game_over),
        .ate       (ate),
        .length    (length)
    );

    // Board RAM, port B; pre_* lets the bench place food and walls while idle.
    logic [3:0] mem [16][32];
    logic       pre_en = 1'b0;
    int         pre_x = 0, pre_y = 0;
    logic [3:0] pre_code = 4'd0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_y][pre_x] <= pre_code;
        else if (write_b) mem[y_b][x_b] <= in_b;
        if (read_b) out_b <= mem[y_b][x_b];
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]       id;
        logic [15:0]      cycles;
        logic [8:0]       len;
        logic [3:0]       ates;
        logic             go;
        logic             full;
        logic [2:0]       n;
        logic [5:0][4:0]  cx;
        logic [5:0][3:0]  cy;
        logic [5:0][3:0]  code;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    exp_t mon_e;

    task automatic chk(input string name, input int id, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d actual %0d required %0d", name, id, act, req);
        end
    endtask

    task automatic exp_new(input int id, input int cyc, input int len, input int ates,
                           input bit go, input bit full);
        cur        = '0;
        cur.id     = 8'(id);
        cur.cycles = 16'(cyc);
        cur.len    = 9'(len);
        cur.ates   = 4'(ates);
        cur.go     = go;
        cur.full   = full;
    endtask

    task automatic exp_cell(input int x, input int y, input int code);
        cur.cx[cur.n]   = 5'(x);
        cur.cy[cur.n]   = 4'(y);
        cur.code[cur.n] = 4'(code);
        cur.n           = cur.n + 3'd1;
    endtask

    task automatic exp_push();
        sb_q.push_back(cur);
    endtask

    function automatic int board_bad(input exp_t e);
        int bad = 0;
        for (int yy = 0; yy < 16; yy++) begin
            for (int xx = 0; xx < 32; xx++) begin
                logic [3:0] ev;
                ev = 4'd0;
                for (int k = 0; k < 6; k++)
                    if (k < int'(e.n) && int'(e.cx[k]) == xx && int'(e.cy[k]) == yy)
                        ev = e.code[k];
                if (mem[yy][xx] !== ev) bad++;
            end
        end
        return bad;
    endfunction

    // Monitor: a busy window closes when busy falls; compare it to the queue head.
    int mcyc = 0, mates = 0, overlap = 0;
    bit prev_busy = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            mcyc      = 0;
            mates     = 0;
            prev_busy = 1'b1;
        end else begin
            if (read_b && write_b) overlap++;
            if (busy) begin
                if (!prev_busy) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_busy actual busy=1 required busy=0 at %0t", $time);
                    end
                end
                mcyc++;
                if (ate) mates++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual busy fell required no step pending at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("busy_cycles", int'(mon_e.id), mcyc, int'(mon_e.cycles));
                    chk("length", int'(mon_e.id), int'(length), int'(mon_e.len));
                    chk("ate_pulses", int'(mon_e.id), mates, int'(mon_e.ates));
                    chk("game_over", int'(mon_e.id), int'(game_over), int'(mon_e.go));
                    if (mon_e.full)
                        chk("board_bad_cells", int'(mon_e.id), board_bad(mon_e), 0);
                    else
                        for (int k = 0; k < int'(mon_e.n); k++)
                            chk("cell", int'(mon_e.id),
                                int'(mem[mon_e.cy[k]][mon_e.cx[k]]), int'(mon_e.code[k]));
                end
                mcyc  = 0;
                mates = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic finish_sim();
        chk("rw_exclusive", 0, overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_done(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout actual %0d steps pending required 0", sb_q.size());
            finish_sim();
        end
    endtask

    task automatic do_tick(input logic [1:0] d);
        @(posedge clk); #1;
        dir_in = d;
        tick   = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic preload(input int x, input int y, input logic [3:0] code);
        @(posedge clk); #1;
        pre_x    = x;
        pre_y    = y;
        pre_code = code;
        pre_en   = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic push_init(input int id);
        exp_new(id, 515, 3, 0, 1'b0, 1'b1);
        exp_cell(14, 8, 5);
        exp_cell(15, 8, 5);
        exp_cell(16, 8, 5);
        exp_push();
    endtask

    task automatic reset_seq(input int id);
        push_init(id);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_x_b", id, int'(x_b), 0);
        chk("rst_y_b", id, int'(y_b), 0);
        chk("rst_rw", id, int'({read_b, write_b}), 0);
        chk("rst_in_b", id, int'(in_b), 0);
        chk("rst_busy", id, int'(busy), 1);
        chk("rst_game_over", id, int'(game_over), 0);
        chk("rst_ate", id, int'(ate), 0);
        chk("rst_length", id, int'(length), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done(700);
    endtask

    initial begin
        reset_seq(0);

        // Plain advance to the right.
        exp_new(1, 7, 3, 0, 1'b0, 1'b1);
        exp_cell(15, 8, 5); exp_cell(16, 8, 5); exp_cell(17, 8, 5);
        exp_push();
        do_tick(2'd1);
        wait_done(50);

        // Reversal (left while heading right) is ignored.
        exp_new(2, 7, 3, 0, 1'b0, 1'b1);
        exp_cell(16, 8, 5); exp_cell(17, 8, 5); exp_cell(18, 8, 5);
        exp_push();
        do_tick(2'd3);
        wait_done(50);

        // Turn up.
        exp_new(3, 7, 3, 0, 1'b0, 1'b1);
        exp_cell(17, 8, 5); exp_cell(18, 8, 4); exp_cell(18, 7, 4);
        exp_push();
        do_tick(2'd0);
        wait_done(50);

        for (int y = 6; y >= 0; y--) begin
            exp_new(10 + (6 - y), 7, 3, 0, 1'b0, 1'b0);
            exp_cell(18, y, 4);
            exp_cell(18, y + 1, 4);
            exp_push();
            do_tick(2'd0);
            wait_done(50);
        end

        // Up from row 0 wraps to row 15; down request is a reversal.
        exp_new(20, 7, 3, 0, 1'b0, 1'b1);
        exp_cell(18, 1, 4); exp_cell(18, 0, 4); exp_cell(18, 15, 4);
        exp_push();
        do_tick(2'd2);
        wait_done(50);

        // Food right in front of the initial head.
        reset_seq(30);
        preload(17, 8, CELL_FOOD);
        exp_new(31, 4, 4, 1, 1'b0, 1'b1);
        exp_cell(14, 8, 5); exp_cell(15, 8, 5); exp_cell(16, 8, 5); exp_cell(17, 8, 5);
        exp_push();
        do_tick(2'd1);
        wait_done(50);

        exp_new(32, 7, 4, 0, 1'b0, 1'b1);
        exp_cell(15, 8, 5); exp_cell(16, 8, 5); exp_cell(17, 8, 5); exp_cell(18, 8, 5);
        exp_push();
        do_tick(2'd1);
        wait_done(50);

        // Wall ahead: game over, board untouched.
        preload(19, 8, CELL_WALL);
        exp_new(33, 2, 4, 0, 1'b1, 1'b1);
        exp_cell(15, 8, 5); exp_cell(16, 8, 5); exp_cell(17, 8, 5); exp_cell(18, 8, 5);
        exp_cell(19, 8, 2);
        exp_push();
        do_tick(2'd1);
        wait_done(50);

        do_tick(2'd1);
        do_tick(2'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("over_busy", 34, int'(busy), 0);
        chk("over_game_over", 34, int'(game_over), 1);
        chk("over_length", 34, int'(length), 4);
        chk("over_wall_cell", 34, int'(mem[8][19]), 2);
        chk("over_head_cell", 34, int'(mem[8][18]), 5);

        // Reset out of OVER must clear game_over and redraw the board.
        reset_seq(40);

        // Reset landing in WR_OLD abandons the step and restarts the clear.
        push_init(41);
        do_tick(2'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_write_masked", 41, int'(write_b), 0);
        chk("abort_busy", 41, int'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_clear_write", 41, int'(write_b), 1);
        chk("abort_clear_xy", 41, int'({x_b, y_b}), 0);
        chk("abort_clear_data", 41, int'(in_b), 0);
        chk("abort_game_over", 41, int'(game_over), 0);
        wait_done(700);

        finish_sim();
    end

endmodule
